uio_bus_arbiter: RTL and testbench

//  Shares the 8-bit bidirectional uio pad bus (uio_out/uio_oe) of the tt_um top between N_REQ internal requesters.

---
 rtl/uio_bus_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit uio pad bus between N_REQ requesters, with a turnaround gap between owners.
// Optional burst limit enabled by defining UIO_BURST_LIMIT_EN.
module uio_bus_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned TURN_CYC  = 1,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         dout_i,
  input  logic [8*N_REQ-1:0]         oe_i,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   owner_id,
  output logic                       busy,
  output logic                       preempt,
  output logic [7:0]                 uio_out,
  output logic [7:0]                 uio_oe
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam logic [3:0] TURN_LOAD = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

  if (N_REQ < 2 || N_REQ > 8) begin : g_chk_nreq
    $error("uio_bus_arbiter: N_REQ out of range");
  end
  if (TURN_CYC > 15) begin : g_chk_turn
    $error("uio_bus_arbiter: TURN_CYC out of range");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_burst
    $error("uio_bus_arbiter: MAX_BURST out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [3:0]       turn_cnt_q, turn_cnt_d;

  logic             found;
  logic [IDW-1:0]   winner;
  int unsigned      scan_idx;
  logic [IDW-1:0]   next_ptr;
  logic             rel;
  logic             burst_hit;
  logic             preempt_c;

  // First requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % N_REQ;
      if (!found && req[scan_idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[IDW-1:0];
      end
    end
  end

  assign next_ptr = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign rel      = !req[owner_q] || !ena;

`ifdef UIO_BURST_LIMIT_EN
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  assign burst_hit = (burst_cnt_q == BW'(MAX_BURST));

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE && ena && found) begin
      burst_cnt_d = BW'(1);
    end else if (state_q == GRANT && !burst_hit) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    gnt_d      = gnt_q;
    turn_cnt_d = turn_cnt_q;
    preempt_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ena && found) begin
          state_d = GRANT;
          owner_d = winner;
          gnt_d   = N_REQ'(1) << winner;
        end
      end
      GRANT: begin
        // A voluntary release wins over the burst limit, so preempt only fires when the owner still wants the bus.
        if (rel || burst_hit) begin
          preempt_c = !rel;
          gnt_d     = '0;
          rr_ptr_d  = next_ptr;
          if (TURN_CYC > 0) begin
            state_d    = TURN;
            turn_cnt_d = TURN_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TURN: begin
        if (turn_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      gnt_q      <= '0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  assign gnt      = gnt_q;
  assign owner_id = owner_q;
  assign busy     = (state_q == GRANT);
  assign preempt  = preempt_c;

  always_comb begin
    uio_out = '0;
    uio_oe  = '0;
    if (busy) begin
      uio_out = dout_i[{owner_q, 3'b000} +: 8];
      uio_oe  = oe_i[{owner_q, 3'b000} +: 8];
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter (N_REQ=4, TURN_CYC=1, MAX_BURST=16); grant order is scoreboarded.
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [3:0]  req;
  logic [31:0] dout_i;
  logic [31:0] oe_i;
  logic [3:0]  gnt;
  logic [1:0]  owner_id;
  logic        busy;
  logic        preempt;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  logic [3:0] prev_gnt = 4'b0000;
  int         mon_e;
  logic [3:0] mon_gnt;
  logic [7:0] mon_out;
  logic [7:0] mon_oe;

  uio_bus_arbiter #(.N_REQ(4), .TURN_CYC(1), .MAX_BURST(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .req      (req),
    .dout_i   (dout_i),
    .oe_i     (oe_i),
    .gnt      (gnt),
    .owner_id (owner_id),
    .busy     (busy),
    .preempt  (preempt),
    .uio_out  (uio_out),
    .uio_oe   (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Scoreboard: every new grant must match the next owner pushed by the stimulus.
  always @(negedge clk) begin
    if (rst === 1'b0 && gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_grant gnt=%b owner_id=%0d, required no grant", gnt, owner_id);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_gnt = 4'b0001 << mon_e;
        mon_out = dout_i[mon_e*8 +: 8];
        mon_oe  = oe_i[mon_e*8 +: 8];
        if (gnt !== mon_gnt || owner_id !== 2'(mon_e) || busy !== 1'b1 ||
            uio_out !== mon_out || uio_oe !== mon_oe) begin
          fails++;
          $display("FAIL sb_grant got gnt=%b id=%0d busy=%b out=%h oe=%h, required gnt=%b id=%0d busy=1 out=%h oe=%h",
                   gnt, owner_id, busy, uio_out, uio_oe, mon_gnt, mon_e, mon_out, mon_oe);
        end
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; req = 4'b0000;
    repeat (3) cyc();
    rst = 1'b0;
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0 || busy !== 1'b0 || uio_oe !== 8'h00 || uio_out !== 8'h00 || owner_id !== 2'd0 || preempt !== 1'b0) begin
      fails++;
      $display("FAIL reset_state gnt=%b busy=%b oe=%h out=%h id=%0d pre=%b, required all 0",
               gnt, busy, uio_oe, uio_out, owner_id, preempt);
    end
    cyc(); ena = 1'b1; req = 4'b0100; exp_q.push_back(2);
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0100) begin
      fails++; $display("FAIL reset_pre_grant gnt=%b, required 0100", gnt);
    end
    cyc(); rst = 1'b1; req = 4'b0000;
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0 || busy !== 1'b0 || uio_oe !== 8'h00 || uio_out !== 8'h00 || owner_id !== 2'd0 || preempt !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_grant gnt=%b busy=%b oe=%h out=%h id=%0d pre=%b, required all 0",
               gnt, busy, uio_oe, uio_out, owner_id, preempt);
    end
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0 || busy !== 1'b0 || uio_oe !== 8'h00) begin
      fails++; $display("FAIL reset_held gnt=%b busy=%b oe=%h, required 0", gnt, busy, uio_oe);
    end
    cyc(); rst = 1'b0;
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_idle gnt=%b busy=%b, required 0", gnt, busy);
    end
  endtask

  task automatic test_single();
    cyc(); req = 4'b0100; exp_q.push_back(2);
    smp();
    tests++;
    if (gnt !== 4'b0000) begin
      fails++; $display("FAIL single_latency gnt=%b, required 0000", gnt);
    end
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0100 || owner_id !== 2'd2 || uio_out !== 8'hA5 || uio_oe !== 8'hFF || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant gnt=%b id=%0d out=%h oe=%h busy=%b, required 0100 2 a5 ff 1",
               gnt, owner_id, uio_out, uio_oe, busy);
    end
    cyc(); req = 4'b0000;
    smp();
    tests++;
    if (gnt !== 4'b0100) begin
      fails++; $display("FAIL single_hold gnt=%b, required 0100", gnt);
    end
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0000 || uio_oe !== 8'h00 || uio_out !== 8'h00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_turn gnt=%b oe=%h out=%h busy=%b, required 0000 00 00 0", gnt, uio_oe, uio_out, busy);
    end
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0000 || uio_oe !== 8'h00) begin
      fails++; $display("FAIL single_idle gnt=%b oe=%h, required 0000 00", gnt, uio_oe);
    end
  endtask

  task automatic test_round_robin();
    int len  = 0;
    int gap  = 0;
    int seen = 0;
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; req = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int c = 0; c < 80 && seen < 5; c++) begin
      smp();
      if (gnt !== 4'b0000) begin
        if (len == 0 && seen > 0) begin
          tests++;
          if (gap != 2) begin
            fails++; $display("FAIL rr_gap grant %0d gap=%0d, required 2", seen, gap);
          end
        end
        len++;
      end else if (len > 0) begin
        tests++;
        if (len != 3) begin
          fails++; $display("FAIL rr_len grant %0d len=%0d, required 3", seen, len);
        end
        seen++; len = 0; gap = 1;
      end else if (seen > 0) begin
        gap++;
      end
      cyc();
      if (len == 2) req[seen % 4] = 1'b0;
      else if (len == 0 && seen > 0 && seen < 5 && gap == 1) req = 4'b1111;
      if (seen == 5) req = 4'b0000;
    end
    tests++;
    if (seen != 5) begin
      fails++; $display("FAIL rr_complete grants=%0d, required 5", seen);
    end
    req = 4'b0000;
    repeat (3) cyc();
  endtask

  task automatic test_ena();
    int bad = 0;
    req = 4'b0010; exp_q.push_back(1);
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0010) begin
      fails++; $display("FAIL ena_grant gnt=%b, required 0010", gnt);
    end
    cyc(); ena = 1'b0; req = 4'b1111;
    smp();
    tests++;
    if (gnt !== 4'b0010) begin
      fails++; $display("FAIL ena_release_latency gnt=%b, required 0010", gnt);
    end
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0000 || uio_oe !== 8'h00) begin
      fails++; $display("FAIL ena_release gnt=%b oe=%h, required 0000 00", gnt, uio_oe);
    end
    for (int c = 0; c < 10; c++) begin
      cyc(); smp();
      if (gnt !== 4'b0000) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL ena_block cycles_with_grant=%0d, required 0", bad);
    end
    cyc(); ena = 1'b1; exp_q.push_back(2);
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0100) begin
      fails++; $display("FAIL ena_resume gnt=%b, required 0100", gnt);
    end
    cyc(); req = 4'b0000;
    repeat (4) cyc();
  endtask

  task automatic test_burst();
    int first_len = 0;
    int gap_len   = 0;
    int phase     = 0;
    int pre_cnt   = 0;
    int pre_at    = -1;
    req = 4'b0001; exp_q.push_back(0);
`ifdef UIO_BURST_LIMIT_EN
    exp_q.push_back(0); exp_q.push_back(0);
`endif
    for (int c = 0; c < 40; c++) begin
      smp();
      if (preempt === 1'b1 && phase < 2) begin
        pre_cnt++;
        if (pre_at < 0) pre_at = c;
      end
      if (gnt[0] === 1'b1) begin
        if (phase == 0) first_len++;
        else if (phase == 1) phase = 2;
      end else if (first_len > 0 && phase == 0) begin
        phase = 1; gap_len = 1;
      end else if (phase == 1) begin
        gap_len++;
      end
      cyc();
    end
    req = 4'b0000;
    repeat (5) cyc();
`ifdef UIO_BURST_LIMIT_EN
    tests++;
    if (first_len != 16) begin
      fails++; $display("FAIL burst_len len=%0d, required 16", first_len);
    end
    tests++;
    if (pre_cnt != 1 || pre_at != 16) begin
      fails++; $display("FAIL burst_preempt pulses=%0d at=%0d, required 1 at 16", pre_cnt, pre_at);
    end
    tests++;
    if (gap_len != 2 || phase != 2) begin
      fails++; $display("FAIL burst_regrant gap=%0d phase=%0d, required gap 2 phase 2", gap_len, phase);
    end
`else
    tests++;
    if (first_len != 39 || phase != 0) begin
      fails++; $display("FAIL burst_hold len=%0d phase=%0d, required 39 0", first_len, phase);
    end
    tests++;
    if (pre_cnt != 0) begin
      fails++; $display("FAIL burst_preempt pulses=%0d, required 0", pre_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    req = 4'b0010; exp_q.push_back(1);
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0010) begin
      fails++; $display("FAIL wrap_setup gnt=%b, required 0010", gnt);
    end
    cyc(); req = 4'b0000;
    repeat (3) cyc();
    req = 4'b1010; exp_q.push_back(3); exp_q.push_back(1);
    cyc(); smp();
    tests++;
    if (gnt !== 4'b1000 || owner_id !== 2'd3 || uio_out !== 8'h44 || uio_oe !== 8'h3C) begin
      fails++;
      $display("FAIL wrap_first gnt=%b id=%0d out=%h oe=%h, required 1000 3 44 3c", gnt, owner_id, uio_out, uio_oe);
    end
    cyc(); req = 4'b0010;
    smp();
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0000) begin
      fails++; $display("FAIL wrap_turn gnt=%b, required 0000", gnt);
    end
    cyc(); smp();
    cyc(); smp();
    tests++;
    if (gnt !== 4'b0010 || owner_id !== 2'd1 || uio_out !== 8'h22) begin
      fails++; $display("FAIL wrap_second gnt=%b id=%0d out=%h, required 0010 1 22", gnt, owner_id, uio_out);
    end
    cyc(); req = 4'b0000;
    repeat (4) cyc();
  endtask

  initial begin
    dout_i = {8'h44, 8'hA5, 8'h22, 8'h11};
    oe_i   = {8'h3C, 8'hFF, 8'hF0, 8'h0F};
    rst = 1'b1; ena = 1'b0; req = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_ena();
    test_burst();
    test_wrap();
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL sb_drain pending=%0d, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
